// File: rtl/mmio_ctrl_pkg.sv
// mmio_ctrl_pkg
// Shared definitions for the MMIO / performance-counter block:
//   - default MMIO window base address
//   - register offsets within the window
//   - RX buffer and TX FSM state encodings
package mmio_ctrl_pkg;

  localparam logic [31:0] MMIO_BASE_ADDR = 32'h8000_0000;

  localparam logic [7:0] OFF_UART_CTRL = 8'h00;  // read: {rx_full, tx_idle}
  localparam logic [7:0] OFF_UART_RX   = 8'h04;  // read: RX byte, pops buffer
  localparam logic [7:0] OFF_UART_TX   = 8'h08;  // write: TX byte
  localparam logic [7:0] OFF_CYC_CNT   = 8'h10;  // read: cycle counter
  localparam logic [7:0] OFF_INST_CNT  = 8'h14;  // read: retired-instruction counter
  localparam logic [7:0] OFF_CNT_CLR   = 8'h18;  // write: clear all counters
  localparam logic [7:0] OFF_BR_CNT    = 8'h1C;  // read: branch counter (optional)

  typedef enum logic {
    RX_EMPTY = 1'b0,
    RX_FULL  = 1'b1
  } rx_state_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_t;

endpackage

// File: rtl/mmio_ctrl_perf_counter.sv
// perf_counter
// Free-running W_SIZE-bit event counter with synchronous clear.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one event this cycle
//   clr        : clear to zero (takes priority over inc)
//   cnt        : current count, wraps modulo 2^W_SIZE
module perf_counter #(
  parameter int W_SIZE = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              clr,
  output logic [W_SIZE-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + W_SIZE'(1);
    end
  end

endmodule

// File: rtl/mmio_ctrl.sv
// mmio_ctrl
// Memory-mapped I/O and performance-counter block. Decodes X-stage
// loads/stores in the MMIO window, owns a 1-entry UART RX buffer, the UART
// TX holding register, and the cycle/instruction counters. All readable
// values are registered every cycle into *_w outputs so they line up with
// the W-stage instruction one cycle later.
//
// Build option: define MMIO_BRANCH_CNT_EN to add a branch counter readable
// through br_cnt_w; otherwise br_cnt_w is tied to zero and branch_w ignored.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   addr_x, wdata_x : X-stage effective address / store data
//   load_x, store_x : X-stage access qualifiers (deasserted on flush)
//   inst_valid_w    : W stage retires a real instruction
//   branch_w        : W-stage instruction is a conditional branch
//   rx_data/valid/ready : UART receiver byte handshake (rx_ready = buffer empty)
//   tx_data/valid/ready : UART transmitter byte handshake
//   uart_ctrl_w, uart_rx_w, cyc_cnt_w, inst_cnt_w, br_cnt_w : W-aligned reads
module mmio_ctrl
  import mmio_ctrl_pkg::*;
#(
  parameter int                W_SIZE    = 32,
  parameter logic [W_SIZE-1:0] MMIO_BASE = W_SIZE'(MMIO_BASE_ADDR)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_SIZE-1:0] addr_x,
  input  logic [W_SIZE-1:0] wdata_x,
  input  logic              load_x,
  input  logic              store_x,
  input  logic              inst_valid_w,
  input  logic              branch_w,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [W_SIZE-1:0] uart_ctrl_w,
  output logic [W_SIZE-1:0] uart_rx_w,
  output logic [W_SIZE-1:0] cyc_cnt_w,
  output logic [W_SIZE-1:0] inst_cnt_w,
  output logic [W_SIZE-1:0] br_cnt_w
);

  rx_state_t         rx_state, rx_state_nxt;
  tx_state_t         tx_state, tx_state_nxt;
  logic [7:0]        rx_buf;
  logic              rx_capture, tx_capture;
  logic              rx_full, tx_idle;
  logic              rx_pop, tx_write, cnt_clr;
  logic [W_SIZE-1:0] cyc_cnt, inst_cnt;

  // Full-width compare so aliases outside the window have no side effects.
  assign rx_pop   = load_x  && (addr_x == MMIO_BASE + W_SIZE'(OFF_UART_RX));
  assign tx_write = store_x && (addr_x == MMIO_BASE + W_SIZE'(OFF_UART_TX));
  assign cnt_clr  = store_x && (addr_x == MMIO_BASE + W_SIZE'(OFF_CNT_CLR));

  assign rx_full  = (rx_state == RX_FULL);
  assign tx_idle  = (tx_state == TX_IDLE);
  assign rx_ready = ~rx_full;
  assign tx_valid = (tx_state == TX_SEND);

  // RX buffer and TX FSM state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_EMPTY;
      tx_state <= TX_IDLE;
      rx_buf   <= '0;
      tx_data  <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      tx_state <= tx_state_nxt;
      if (rx_capture) rx_buf  <= rx_data;
      if (tx_capture) tx_data <= wdata_x[7:0];
    end
  end

  // rx_valid is only looked at while EMPTY; a pop while EMPTY leaves
  // rx_buf untouched so the read returns the stale byte.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_capture   = 1'b0;
    case (rx_state)
      RX_EMPTY: if (rx_valid) begin
        rx_capture   = 1'b1;
        rx_state_nxt = RX_FULL;
      end
      RX_FULL:  if (rx_pop) rx_state_nxt = RX_EMPTY;
      default:  rx_state_nxt = RX_EMPTY;
    endcase
  end

  // A TX store while SEND is dropped; software polls tx_idle first.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_capture   = 1'b0;
    case (tx_state)
      TX_IDLE: if (tx_write) begin
        tx_capture   = 1'b1;
        tx_state_nxt = TX_SEND;
      end
      TX_SEND: if (tx_ready) tx_state_nxt = TX_IDLE;
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  perf_counter #(.W_SIZE(W_SIZE)) u_cyc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .clr   (cnt_clr),
    .cnt   (cyc_cnt)
  );

  perf_counter #(.W_SIZE(W_SIZE)) u_inst_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inst_valid_w),
    .clr   (cnt_clr),
    .cnt   (inst_cnt)
  );

  // X -> W read registers, refreshed every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_ctrl_w <= '0;
      uart_rx_w   <= '0;
      cyc_cnt_w   <= '0;
      inst_cnt_w  <= '0;
    end else begin
      uart_ctrl_w <= {{(W_SIZE-2){1'b0}}, rx_full, tx_idle};
      uart_rx_w   <= {{(W_SIZE-8){1'b0}}, rx_buf};
      cyc_cnt_w   <= cyc_cnt;
      inst_cnt_w  <= inst_cnt;
    end
  end

`ifdef MMIO_BRANCH_CNT_EN
  logic [W_SIZE-1:0] br_cnt;

  perf_counter #(.W_SIZE(W_SIZE)) u_br_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inst_valid_w & branch_w),
    .clr   (cnt_clr),
    .cnt   (br_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_w <= '0;
    end else begin
      br_cnt_w <= br_cnt;
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^wdata_x[W_SIZE-1:8];
`else
  assign br_cnt_w = '0;

  logic unused_inputs;
  assign unused_inputs = ^{wdata_x[W_SIZE-1:8], branch_w};
`endif

endmodule
